// File: rtl/k12a_mem_ctrl_if.sv
// Purpose: bundles the core-side request bus and board-level memory pins of k12a_mem_ctrl.
// Latency: none, wires only.
// Backpressure: none here; the controller signals completion with a mem_ready pulse.
// Signals:
//   core side  : addr_bus, addr_latch, mem_req, mem_write, mem_wdata -> ctrl
//                mem_rdata, mem_ready, mem_busy, rom_wr_err <- ctrl
//   board side : ext_addr, ram_ce_n, rom_ce_n, io_ce_n, ext_oe_n, ext_we_n,
//                ext_dq_out, ext_dq_oe <- ctrl;  ext_dq_in -> ctrl
interface k12a_mem_ctrl_if;
    logic [15:0] addr_bus;
    logic        addr_latch;
    logic        mem_req;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        mem_busy;
    logic        rom_wr_err;
    logic [14:0] ext_addr;
    logic        ram_ce_n;
    logic        rom_ce_n;
    logic        io_ce_n;
    logic        ext_oe_n;
    logic        ext_we_n;
    logic [7:0]  ext_dq_out;
    logic        ext_dq_oe;
    logic [7:0]  ext_dq_in;

    // Controller side.
    modport slave (
        input  addr_bus, addr_latch, mem_req, mem_write, mem_wdata, ext_dq_in,
        output mem_rdata, mem_ready, mem_busy, rom_wr_err, ext_addr,
               ram_ce_n, rom_ce_n, io_ce_n, ext_oe_n, ext_we_n, ext_dq_out, ext_dq_oe
    );

    // Core / board side.
    modport master (
        output addr_bus, addr_latch, mem_req, mem_write, mem_wdata, ext_dq_in,
        input  mem_rdata, mem_ready, mem_busy, rom_wr_err, ext_addr,
               ram_ce_n, rom_ce_n, io_ce_n, ext_oe_n, ext_we_n, ext_dq_out, ext_dq_oe
    );
endinterface

// File: rtl/k12a_mem_ctrl.sv
// Purpose: latches the shared address bus, decodes RAM/ROM/IO and runs a fixed-wait byte access.
// Latency: mem_ready pulses WAIT_STATES+3 cycles after the request edge; one transfer per WAIT_STATES+4 cycles.
// Backpressure: mem_req is only taken in IDLE; mem_busy high means requests are ignored.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (slave)    : core request/response signals and board-level memory pins
module k12a_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    k12a_mem_ctrl_if.slave bus
);
    // At least one counter bit so WAIT_STATES=0 still builds.
    localparam int unsigned CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [7:0]      dq_out_q, dq_out_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            active;
    logic            in_ram;
    logic            in_rom;
    logic            in_io;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            dq_out_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            dq_out_q <= dq_out_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        dq_out_d = dq_out_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                // Latch and request in the same cycle: the transfer uses this cycle's bus value,
                // because addr_q is what the following states decode.
                if (bus.addr_latch) begin
                    addr_d = bus.addr_bus;
                end
                if (bus.mem_req) begin
                    wr_d     = bus.mem_write;
                    dq_out_d = bus.mem_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CW'(WAIT_STATES);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // Sampled at the end of DONE so the device has had the whole strobe window.
                if (!wr_q) begin
                    rdata_d = bus.ext_dq_in;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign active = (state_q != IDLE);
    assign in_ram = ~addr_q[15];
    assign in_rom = addr_q[15] & ~addr_q[14];
    assign in_io  = addr_q[15] &  addr_q[14];

    assign bus.ram_ce_n   = ~(active & in_ram);
    assign bus.rom_ce_n   = ~(active & in_rom);
    assign bus.io_ce_n    = ~(active & in_io);
    assign bus.ext_oe_n   = ~(active & ~wr_q);
    // Data drivers cover SETUP..DONE, so the write strobe (ACCESS only) never coincides
    // with a driver edge. ROM writes keep the strobe high and are flagged instead.
    assign bus.ext_dq_oe  = active & wr_q;
    assign bus.ext_we_n   = ~((state_q == ACCESS) & wr_q & ~in_rom);
    assign bus.ext_dq_out = dq_out_q;
    assign bus.ext_addr   = addr_q[14:0];

    assign bus.mem_busy   = active;
    assign bus.mem_ready  = (state_q == DONE);
    assign bus.rom_wr_err = (state_q == DONE) & wr_q & in_rom;
    assign bus.mem_rdata  = rdata_q;
endmodule

// File: tb/tb_k12a_mem_ctrl.sv
// Purpose: self-checking bench for k12a_mem_ctrl with WAIT_STATES 1 (main), 0 and 7 instances.
// Latency: checks ready at WAIT_STATES+3 edges after the request edge and WAIT_STATES+4 spacing.
// Backpressure: new requests are issued only once the main instance is back in IDLE.
module tb_k12a_mem_ctrl;
    localparam int WS1 = 1;

    logic        clock;
    logic        reset_n;
    logic [15:0] addr_bus;
    logic        addr_latch;
    logic        mem_req;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  ext_dq_in;

    int n_checks;
    int n_fail;

    // Reference model state: last latched address and last completed read.
    logic [15:0] model_addr;
    logic [7:0]  model_rdata;

    // Observations of the last transfer, for the table comparisons.
    logic [2:0]  obs_ce;
    logic        obs_err;
    logic [7:0]  obs_rdata;

    k12a_mem_ctrl_if if1 ();
    k12a_mem_ctrl_if if0 ();
    k12a_mem_ctrl_if if7 ();

    assign if1.addr_bus = addr_bus;   assign if0.addr_bus = addr_bus;   assign if7.addr_bus = addr_bus;
    assign if1.addr_latch = addr_latch; assign if0.addr_latch = addr_latch; assign if7.addr_latch = addr_latch;
    assign if1.mem_req = mem_req;     assign if0.mem_req = mem_req;     assign if7.mem_req = mem_req;
    assign if1.mem_write = mem_write; assign if0.mem_write = mem_write; assign if7.mem_write = mem_write;
    assign if1.mem_wdata = mem_wdata; assign if0.mem_wdata = mem_wdata; assign if7.mem_wdata = mem_wdata;
    assign if1.ext_dq_in = ext_dq_in; assign if0.ext_dq_in = ext_dq_in; assign if7.ext_dq_in = ext_dq_in;

    k12a_mem_ctrl #(.WAIT_STATES(WS1)) u_dut  (.clock(clock), .reset_n(reset_n), .bus(if1));
    k12a_mem_ctrl #(.WAIT_STATES(0))   u_dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    k12a_mem_ctrl #(.WAIT_STATES(7))   u_dut7 (.clock(clock), .reset_n(reset_n), .bus(if7));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Region from plain address ranges: 0 = RAM, 1 = ROM, 2 = IO.
    function automatic int region_of(input logic [15:0] a);
        if (a < 16'h8000) return 0;
        else if (a < 16'hC000) return 1;
        else return 2;
    endfunction

    function automatic int strobes1();
        return int'({if1.ram_ce_n, if1.rom_ce_n, if1.io_ce_n, if1.ext_oe_n, if1.ext_we_n});
    endfunction

    // Issues one transfer on the WS1 instance starting in the current low clock phase,
    // scrambles the core inputs while busy (including addr_latch and a DONE-cycle mem_req),
    // and compares per-cycle observations against the model. Returns just after a negedge in IDLE.
    task automatic do_xfer(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                           input logic [7:0] dq, input logic lat);
        int rg, exp_len, exp_err, ready_k, n_ready, err_cnt, err_at_rdy;
        int we_cnt, we_out, oe_cnt, dqoe_cnt, dq_bad, addr_bad, inv_bad, busy_cnt, lows;
        int ce0, ce1, ce2, ce_rg;
        logic [7:0] exp_rd;
        ready_k = 0; n_ready = 0; err_cnt = 0; err_at_rdy = 0;
        we_cnt = 0; we_out = 0; oe_cnt = 0; dqoe_cnt = 0; dq_bad = 0;
        addr_bad = 0; inv_bad = 0; busy_cnt = 0; ce0 = 0; ce1 = 0; ce2 = 0;

        addr_bus = a; addr_latch = lat; mem_req = 1'b1;
        mem_write = wr; mem_wdata = wd; ext_dq_in = dq;
        if (lat) model_addr = a;
        rg      = region_of(model_addr);
        exp_len = WS1 + 3;
        exp_err = (wr && rg == 1) ? 1 : 0;
        exp_rd  = wr ? model_rdata : dq;

        @(posedge clock);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (!if1.mem_busy) break;
            busy_cnt++;
            lows = int'(!if1.ram_ce_n) + int'(!if1.rom_ce_n) + int'(!if1.io_ce_n);
            if (lows != 1) inv_bad++;
            if (!if1.ram_ce_n) ce0++;
            if (!if1.rom_ce_n) ce1++;
            if (!if1.io_ce_n)  ce2++;
            if (!if1.ext_oe_n) oe_cnt++;
            if (!if1.ext_we_n) begin
                we_cnt++;
                if (k < 2 || k > WS1 + 2) we_out++;
                if (!if1.ext_oe_n || !if1.ext_dq_oe) inv_bad++;
            end
            if (if1.ext_dq_oe) begin
                dqoe_cnt++;
                if (if1.ext_dq_out !== wd) dq_bad++;
            end
            if (if1.ext_addr !== model_addr[14:0]) addr_bad++;
            if (if1.rom_wr_err) err_cnt++;
            if (if1.mem_ready) begin
                n_ready++;
                ready_k = k;
                err_at_rdy = int'(if1.rom_wr_err);
            end
            mem_req    = (k == exp_len);
            addr_latch = 1'($urandom_range(0, 1));
            addr_bus   = (k == 2) ? 16'hFFFF : 16'($urandom);
            mem_write  = 1'($urandom_range(0, 1));
            mem_wdata  = 8'($urandom);
        end
        mem_req = 1'b0;
        addr_latch = 1'b0;

        ce_rg = (rg == 0) ? ce0 : (rg == 1) ? ce1 : ce2;
        check("xfer busy cycles", busy_cnt, exp_len);
        check("xfer ready pulses", n_ready, 1);
        check("xfer ready latency", ready_k, exp_len);
        check("xfer rom_wr_err pulses", err_cnt, exp_err);
        check("xfer rom_wr_err with ready", err_at_rdy, exp_err);
        check("xfer region enable cycles", ce_rg, exp_len);
        check("xfer other enables", ce0 + ce1 + ce2 - ce_rg, 0);
        check("xfer we_n low cycles", we_cnt, (wr && rg != 1) ? WS1 + 1 : 0);
        check("xfer we_n outside access", we_out, 0);
        check("xfer oe_n low cycles", oe_cnt, wr ? 0 : exp_len);
        check("xfer dq_oe cycles", dqoe_cnt, wr ? exp_len : 0);
        check("xfer dq_out value", dq_bad, 0);
        check("xfer ext_addr held", addr_bad, 0);
        check("xfer strobe rules", inv_bad, 0);
        check("xfer idle strobes", strobes1(), 5'h1F);
        check("xfer rdata", int'(if1.mem_rdata), int'(exp_rd));

        model_rdata = exp_rd;
        obs_ce    = {ce2 != 0, ce1 != 0, ce0 != 0};
        obs_err   = (err_cnt != 0);
        obs_rdata = if1.mem_rdata;
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  dqin;
        logic        lat;
        logic [2:0]  exp_ce;     // {io, rom, ram}
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int r0, r1, r7, n_rdy;
        int q0[$];
        int q1[$];
        int q7[$];

        vecs[0] = '{16'h1234, 1'b0, 8'h00, 8'hA5, 1'b1, 3'b001, 1'b0, 8'hA5};
        vecs[1] = '{16'hC003, 1'b1, 8'h5A, 8'h00, 1'b1, 3'b100, 1'b0, 8'hA5};
        vecs[2] = '{16'h8000, 1'b1, 8'h77, 8'h00, 1'b1, 3'b010, 1'b1, 8'hA5};
        vecs[3] = '{16'h7FFF, 1'b0, 8'h00, 8'h3C, 1'b1, 3'b001, 1'b0, 8'h3C};
        vecs[4] = '{16'hBFFF, 1'b0, 8'h00, 8'h81, 1'b1, 3'b010, 1'b0, 8'h81};
        vecs[5] = '{16'h4000, 1'b1, 8'h00, 8'hFF, 1'b1, 3'b001, 1'b0, 8'h81};
        vecs[6] = '{16'hFFFF, 1'b0, 8'h00, 8'hEE, 1'b1, 3'b100, 1'b0, 8'hEE};
        vecs[7] = '{16'h0000, 1'b0, 8'h00, 8'h11, 1'b0, 3'b100, 1'b0, 8'h11};

        n_checks = 0; n_fail = 0;
        reset_n = 1'b0; addr_bus = '0; addr_latch = 1'b0; mem_req = 1'b0;
        mem_write = 1'b0; mem_wdata = '0; ext_dq_in = '0;
        model_addr = '0; model_rdata = '0;

        // Reset and hold.
        repeat (3) @(negedge clock);
        check("reset strobes", strobes1(), 5'h1F);
        check("reset busy", int'(if1.mem_busy), 0);
        check("reset ready", int'(if1.mem_ready), 0);
        check("reset dq_oe", int'(if1.ext_dq_oe), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle strobes", strobes1(), 5'h1F);
        check("idle busy", int'(if1.mem_busy), 0);
        check("idle rdata", int'(if1.mem_rdata), 0);
        check("idle ext_addr", int'(if1.ext_addr), 0);
        check("idle ext_dq_out", int'(if1.ext_dq_out), 0);
        check("idle rom_wr_err", int'(if1.rom_wr_err), 0);

        // Single read on all three builds: ready edge = WAIT_STATES+3.
        r0 = 0; r1 = 0; r7 = 0;
        addr_bus = 16'h0100; addr_latch = 1'b1; mem_req = 1'b1; mem_write = 1'b0; ext_dq_in = 8'h42;
        @(posedge clock);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            mem_req = 1'b0; addr_latch = 1'b0;
            if (if0.mem_ready && r0 == 0) r0 = c;
            if (if1.mem_ready && r1 == 0) r1 = c;
            if (if7.mem_ready && r7 == 0) r7 = c;
        end
        check("ws0 ready latency", r0, 3);
        check("ws1 ready latency", r1, 4);
        check("ws7 ready latency", r7, 10);

        // Back-to-back reads with mem_req held high.
        mem_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (if0.mem_ready) q0.push_back(c);
            if (if1.mem_ready) q1.push_back(c);
            if (if7.mem_ready) q7.push_back(c);
        end
        mem_req = 1'b0;
        check("ws0 b2b completions", int'(q0.size() >= 2), 1);
        check("ws1 b2b completions", int'(q1.size() >= 2), 1);
        check("ws7 b2b completions", int'(q7.size() >= 2), 1);
        if (q0.size() >= 2) check("ws0 b2b spacing", q0[1] - q0[0], 4);
        if (q1.size() >= 2) check("ws1 b2b spacing", q1[1] - q1[0], 5);
        if (q7.size() >= 2) check("ws7 b2b spacing", q7[1] - q7[0], 11);
        repeat (15) @(negedge clock);
        model_addr = 16'h0100; model_rdata = 8'h42;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].dqin, vecs[i].lat);
            check("table chip enable", int'(obs_ce), int'(vecs[i].exp_ce));
            check("table rom_wr_err", int'(obs_err), int'(vecs[i].exp_err));
            check("table rdata", int'(obs_rdata), int'(vecs[i].exp_rdata));
        end

        // Reset during ACCESS of an IO write.
        addr_bus = 16'hC003; addr_latch = 1'b1; mem_req = 1'b1; mem_write = 1'b1; mem_wdata = 8'h5A;
        @(posedge clock);
        @(negedge clock);
        mem_req = 1'b0; addr_latch = 1'b0;
        @(negedge clock);
        check("pre-reset we_n in access", int'(if1.ext_we_n), 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid reset strobes", strobes1(), 5'h1F);
        check("mid reset dq_oe", int'(if1.ext_dq_oe), 0);
        check("mid reset busy", int'(if1.mem_busy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        n_rdy = 0;
        repeat (8) begin
            @(negedge clock);
            if (if1.mem_ready) n_rdy++;
        end
        check("mid reset no ready", n_rdy, 0);
        check("mid reset rdata", int'(if1.mem_rdata), 0);
        check("mid reset ext_addr", int'(if1.ext_addr), 0);
        model_addr = '0; model_rdata = '0;

        // Random transfers against the model.
        for (int i = 0; i < 40; i++) begin
            do_xfer(16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
